// File: rtl/dip_input_pkg.sv
// Shared definitions for the DIP switch input conditioning path:
// debounce FSM state encoding, default settle length and diagnostic widths.
package dip_input_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SETTLE = 2'd2
  } dip_state_t;

  // Consecutive stable cycles a word needs before it is committed.
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Width of the optional restart (glitch) counter.
  localparam int GLITCH_W = 8;

endpackage

// File: rtl/dip_input_debounce_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
// Reusable for any slow asynchronous input; no bus coherence is implied,
// the consumer must tolerate bits landing on different cycles.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // Two register stages to let metastability resolve before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/dip_input_debounce.sv
// DIP switch conditioning in front of the processor's DAT_IN input buffer.
// Synchronizes the raw switches, then commits a new word only after the
// whole word has been stable for DEBOUNCE_CYCLES consecutive cycles.
//
// Handshake with CONTROL: DAT_PEND is a sticky "new data" flag that rises on
// the edge a changed word is committed and falls on any edge with IN_I = 1.
// If a commit and IN_I meet on the same edge the commit wins, because the read
// that cycle saw the previous DAT_IN and the new word is still unread.
//
// Optional build macro: DIP_GLITCH_CNT_EN adds GLITCH_CNT, a saturating count
// of debounce-window restarts.
module dip_input_debounce
  import dip_input_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] SW_RAW,
  input  logic             IN_I,
  output logic [WIDTH-1:0] DAT_IN,
  output logic             DAT_VALID,
  output logic             DAT_PEND,
  output logic [1:0]       state_dbg
`ifdef DIP_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] GLITCH_CNT
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  dip_state_t       state;
  logic             word_changed;
  logic             window_done;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk (Clk),
    .rst (Rst),
    .d   (SW_RAW),
    .q   (s2)
  );

  assign word_changed = (s2 != cand);
  assign window_done  = (cnt == CNT_LAST);
  assign state_dbg    = state;

  // Debounce FSM: tracks a candidate word, counts stable cycles, commits
  // the word to DAT_IN and maintains the valid/pending flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_INIT;
      cand      <= '0;
      cnt       <= '0;
      DAT_IN    <= '0;
      DAT_VALID <= 1'b0;
      DAT_PEND  <= 1'b0;
    end else begin
      // A read consumes the pending flag; a commit below may set it again.
      if (IN_I) DAT_PEND <= 1'b0;

      case (state)
        ST_INIT: begin
          if (word_changed) begin
            cand <= s2;
            cnt  <= '0;
          end else if (window_done) begin
            DAT_IN    <= cand;
            DAT_VALID <= 1'b1;
            cnt       <= '0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (s2 != DAT_IN) begin
            cand  <= s2;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (word_changed) begin
            cand <= s2;
            cnt  <= '0;
          end else if (window_done) begin
            // Bouncing back to the committed word finishes silently.
            if (cand != DAT_IN) DAT_PEND <= 1'b1;
            DAT_IN <= cand;
            cnt    <= '0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DIP_GLITCH_CNT_EN
  logic restart;

  assign restart = ((state == ST_INIT) || (state == ST_SETTLE)) && word_changed;

  // Saturating count of window restarts caused by the word moving mid-count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      GLITCH_CNT <= '0;
    end else if (restart && (GLITCH_CNT != '1)) begin
      GLITCH_CNT <= GLITCH_CNT + 1'b1;
    end
  end
`endif

endmodule
